// File: rtl/io_stall_unit.sv
// I/O and stall controller: stalls the core on Input until a debounced Enter press,
// latches Output data for the display, and freezes the core on HALT.
module io_stall_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_flag,
  input  logic                  output_flag,
  input  logic                  halt,
  input  logic [DATA_WIDTH-1:0] out_data,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  enter_button,
  output logic                  pc_enable,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] display_data,
  output logic                  display_valid,
  output logic                  waiting_input,
  output logic                  halted
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN,
    WAIT_PRESS,
    CAPTURE,
    HALTED
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] cnt;
  logic             press_evt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= enter_button;
      sync2 <= sync1;
    end
  end

  // cnt counts consecutive cycles the synchronized level disagrees with db;
  // reaching DEBOUNCE_CYCLES disagreements accepts the new level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      db   <= 1'b0;
      db_d <= 1'b0;
    end else begin
      db_d <= db;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only a fresh rising edge of db confirms an Input; a held button cannot.
  assign press_evt = db & ~db_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      in_data       <= '0;
      display_data  <= '0;
      display_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (input_flag) begin
            state <= WAIT_PRESS;
          end else if (output_flag) begin
            display_data  <= out_data;
            display_valid <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (press_evt) begin
            in_data <= DATA_WIDTH'(switches);
            state   <= CAPTURE;
          end
        end
        CAPTURE: state <= RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_enable = 1'b0;
    case (state)
      RUN:        pc_enable = ~halt & ~input_flag;
      WAIT_PRESS: pc_enable = 1'b0;
      CAPTURE:    pc_enable = 1'b1;
      HALTED:     pc_enable = 1'b0;
      default:    pc_enable = 1'b0;
    endcase
  end

  assign waiting_input = (state == WAIT_PRESS);
  assign halted        = (state == HALTED);

endmodule

// File: tb/tb_io_stall_unit.sv
// Directed bench for io_stall_unit: reset, Input flow with exact button latency,
// held-button and bounce rejection, Output latch, HALT freeze and async reset.
module tb_io_stall_unit;

  logic        clock;
  logic        reset;
  logic        input_flag;
  logic        output_flag;
  logic        halt;
  logic [31:0] out_data;
  logic [15:0] switches;
  logic        enter_button;
  logic        pc_enable;
  logic [31:0] in_data;
  logic [31:0] display_data;
  logic        display_valid;
  logic        waiting_input;
  logic        halted;

  int unsigned total = 0;
  int unsigned bad   = 0;

  io_stall_unit #(
    .DATA_WIDTH(32),
    .SW_WIDTH(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .input_flag(input_flag),
    .output_flag(output_flag),
    .halt(halt),
    .out_data(out_data),
    .switches(switches),
    .enter_button(enter_button),
    .pc_enable(pc_enable),
    .in_data(in_data),
    .display_data(display_data),
    .display_valid(display_valid),
    .waiting_input(waiting_input),
    .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset        = 1'b1;
    input_flag   = 1'b0;
    output_flag  = 1'b0;
    halt         = 1'b0;
    out_data     = '0;
    switches     = '0;
    enter_button = 1'b0;
    #1;
    chk("rst_pc", {31'd0, pc_enable}, 32'd1);
    chk("rst_in_data", in_data, 32'd0);
    chk("rst_disp_valid", {31'd0, display_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_waiting", {31'd0, waiting_input}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_pc", {31'd0, pc_enable}, 32'd1);
    end

    // Input flow: raw rise sampled at edge 1, capture at edge 7
    switches   = 16'hA5C3;
    input_flag = 1'b1;
    #1;
    chk("in_run_pc", {31'd0, pc_enable}, 32'd0);
    tick();
    chk("in_wait", {31'd0, waiting_input}, 32'd1);
    enter_button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("in_stall_wait", {31'd0, waiting_input}, 32'd1);
      chk("in_stall_pc", {31'd0, pc_enable}, 32'd0);
    end
    tick();
    chk("in_cap_pc", {31'd0, pc_enable}, 32'd1);
    chk("in_cap_wait", {31'd0, waiting_input}, 32'd0);
    chk("in_cap_data", in_data, 32'h0000A5C3);

    // Next instruction is another Input while the button stays held
    switches = 16'h0042;
    tick();
    chk("in_one_cycle_pc", {31'd0, pc_enable}, 32'd0);
    chk("in_run2_wait", {31'd0, waiting_input}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_wait", {31'd0, waiting_input}, 32'd1);
      chk("held_pc", {31'd0, pc_enable}, 32'd0);
    end
    chk("held_data", in_data, 32'h0000A5C3);
    enter_button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("release_wait", {31'd0, waiting_input}, 32'd1);
    end
    enter_button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("repress_wait", {31'd0, waiting_input}, 32'd1);
    end
    tick();
    chk("repress_cap_pc", {31'd0, pc_enable}, 32'd1);
    chk("repress_data", in_data, 32'h00000042);
    input_flag = 1'b0;
    tick();
    chk("repress_run_pc", {31'd0, pc_enable}, 32'd1);
    chk("repress_run_wait", {31'd0, waiting_input}, 32'd0);
    enter_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Bounce: 3-high / 3-low pulses must never confirm
    switches   = 16'h1234;
    input_flag = 1'b1;
    tick();
    chk("bounce_enter_wait", {31'd0, waiting_input}, 32'd1);
    for (int p = 0; p < 5; p++) begin
      enter_button = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("bounce_wait", {31'd0, waiting_input}, 32'd1);
      end
      enter_button = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("bounce_wait", {31'd0, waiting_input}, 32'd1);
      end
    end
    chk("bounce_data", in_data, 32'h00000042);
    enter_button = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stable_wait", {31'd0, waiting_input}, 32'd1);
    end
    tick();
    chk("stable_cap_pc", {31'd0, pc_enable}, 32'd1);
    chk("stable_data", in_data, 32'h00001234);
    input_flag = 1'b0;
    tick();
    enter_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Press while in RUN is ignored
    enter_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("run_press_pc", {31'd0, pc_enable}, 32'd1);
      chk("run_press_wait", {31'd0, waiting_input}, 32'd0);
    end
    input_flag = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_queue_wait", {31'd0, waiting_input}, 32'd1);
    end
    enter_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    switches     = 16'hBEEF;
    enter_button = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("after_run_press_data", in_data, 32'h0000BEEF);
    input_flag = 1'b0;
    tick();
    enter_button = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // Output latch, zero stall
    chk("pre_out_valid", {31'd0, display_valid}, 32'd0);
    out_data    = 32'hDEADBEEF;
    output_flag = 1'b1;
    #1;
    chk("out_pc", {31'd0, pc_enable}, 32'd1);
    tick();
    chk("out_disp", display_data, 32'hDEADBEEF);
    chk("out_valid", {31'd0, display_valid}, 32'd1);
    chk("out_pc_after", {31'd0, pc_enable}, 32'd1);
    output_flag = 1'b0;
    out_data    = 32'h12345678;
    for (int i = 0; i < 3; i++) tick();
    chk("out_persist", display_data, 32'hDEADBEEF);
    chk("out_valid_persist", {31'd0, display_valid}, 32'd1);

    // HALT beats input and output when asserted together
    halt        = 1'b1;
    input_flag  = 1'b1;
    output_flag = 1'b1;
    out_data    = 32'h0000CAFE;
    #1;
    chk("halt_run_pc", {31'd0, pc_enable}, 32'd0);
    tick();
    halt = 1'b0;
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_no_wait", {31'd0, waiting_input}, 32'd0);
    chk("halt_no_disp", display_data, 32'hDEADBEEF);
    switches     = 16'h7777;
    enter_button = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("halt_pc", {31'd0, pc_enable}, 32'd0);
      chk("halt_stay", {31'd0, halted}, 32'd1);
    end
    chk("halt_in_data", in_data, 32'h0000BEEF);
    chk("halt_disp", display_data, 32'hDEADBEEF);

    // Asynchronous reset mid-cycle
    input_flag  = 1'b0;
    output_flag = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", {31'd0, pc_enable}, 32'd1);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    chk("arst_in_data", in_data, 32'd0);
    chk("arst_disp", display_data, 32'd0);
    chk("arst_valid", {31'd0, display_valid}, 32'd0);
    chk("arst_wait", {31'd0, waiting_input}, 32'd0);
    enter_button = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-WAIT_PRESS discards the pending press
    input_flag = 1'b1;
    tick();
    chk("w_rst_wait", {31'd0, waiting_input}, 32'd1);
    enter_button = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    reset = 1'b1;
    input_flag = 1'b0;
    #1;
    chk("w_rst_wait_clr", {31'd0, waiting_input}, 32'd0);
    chk("w_rst_pc", {31'd0, pc_enable}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w_rst_in_data", in_data, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
